rotate_ctrl: RTL and testbench
==============================

# rotate_ctrl

Rotation sequencer for the active Tetris piece. Owns the piece's current block type and x reference. On a rotate request it proposes the rotated type to the combinational rotation collision checker and samples that checker's `stop` result. If rotation is legal it commits the new type; otherwise it optionally tries wall-kick positions before rejecting. It sits directly downstream of the collision checker and upstream of the draw/placement logic that reads `cur_type`/`cur_x`.

## Interface
- `SIZE`, 16, cell size in pixels.
- `X_MIN`, 240, playfield left edge (px).
- `X_MAX`, 400, playfield right edge (px).
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  spawn a new piece this cycle.
- `load_type`  in  4  new piece type (0–10).
- `load_x`  in  10  new piece x reference.
- `x_wr`  in  1  lateral-move write from the move logic.
- `x_in`  in  10  new x on `x_wr`.
- `freeze`  in  1  high while landing or line clear is in progress; blocks new requests.
- `rot_req`  in  1  rotate button level. Rising edge is the request.
- `stop`  in  1  collision result for `cand_type`/`cand_x`.
- `cand_type`  out  4  candidate type to checker.
- `cand_x`  out  10  candidate x to checker.
- `cand_valid`  out  1  candidate is being evaluated.
- `cur_type`  out  4  committed type.
- `cur_x`  out  10  committed x.
- `busy`  out  1  state ≠ IDLE.
- `rot_done`  out  1  one-cycle pulse when a rotation is committed.
- `rot_fail`  out  1  one-cycle pulse when a rotation is rejected.

## Operation
- Rotation map (clockwise):
  - 0→0
  - 1↔2
  - 3→4→5→6→3
  - 7↔8
  - 9↔10
  - 11–15 are invalid.
- Request detection:
  - `rot_req` is registered each cycle; request = current & ~previous.
  - Accepted only in IDLE with `freeze`=0. Other requests are dropped, not queued.
- States: IDLE, PROPOSE, EVAL, DONE, FAIL.
- IDLE:
  - On accept, type 0 goes to DONE with no change.
  - Types 11–15 go to FAIL.
  - Otherwise: `cand_type`=map(`cur_type`), `cand_x`=`cur_x`, attempt=0, go to PROPOSE.
- PROPOSE:
  - `cand_valid`=1. This cycle lets the external grid index settle. Go to EVAL.
- EVAL:
  - `cand_valid`=1; `stop` is sampled.
  - `stop`=0: commit `cur_type`←`cand_type`, `cur_x`←`cand_x`, go to DONE.
  - `stop`=1: retry or go to FAIL (see Configuration).
- DONE: `rot_done`=1, then IDLE. FAIL: `rot_fail`=1, then IDLE.
- In IDLE and DONE/FAIL, `cand_*` mirror `cur_*` and `cand_valid`=0.
- `load`:
  - Highest priority in every state.
  - `cur_type`←`load_type`, `cur_x`←`load_x`, state←IDLE, attempt cleared.
  - No `rot_done`/`rot_fail` is issued for an aborted rotation.
- `x_wr` updates `cur_x` only in IDLE; it is ignored while `busy`. If `load` and `x_wr` are both high, `load` wins.
- `freeze` is sampled only in IDLE. A rotation already in flight completes.
- Kick x arithmetic:
  - 10-bit unsigned, modulo 2^10, no clamping.
  - Out-of-field candidates are rejected by the checker's bound terms.

## Timing
- Reset values:
  - state IDLE
  - `cur_type`=0
  - `cur_x`=X_MIN+4·SIZE (304)
  - `cand_type`=0, `cand_x`=304
  - `cand_valid`=0, `busy`=0, `rot_done`=0, `rot_fail`=0
  - edge register=0
- Request edge sampled at clock edge N (`rot_req` high, previous low):
  - PROPOSE during N..N+1.
  - EVAL during N+1..N+2.
  - `cur_*` update at N+2.
  - `rot_done` high for exactly one cycle, N+2..N+3.
- Each kick retry adds 2 cycles.
- Type 0 or invalid type: pulse at N+1..N+2.
- `busy` is high from N until the DONE/FAIL cycle ends.
- `stop` is ignored outside EVAL.

## Configuration
- `ROT_KICK_EN` defined:
  - EVAL with `stop`=1 and attempt=0: `cand_x`=`cur_x`−SIZE, attempt=1, go to PROPOSE.
  - attempt=1: `cand_x`=`cur_x`+SIZE, attempt=2, go to PROPOSE.
  - attempt=2: FAIL.
  - A successful kick commits the kicked `cand_x`.
- `ROT_KICK_EN` undefined: EVAL with `stop`=1 goes straight to FAIL; `cand_x` always equals `cur_x`.

## Test plan
- Reset, then idle: `cur_type`=0, `cur_x`=304, all pulses 0, `busy`=0.
- `load` type 3 at x=320; `rot_req` edge with `stop`=0 → `cur_type`=4 at N+2, `rot_done` 1 cycle, `cur_x`=320. Three more edges → 5, 6, 3.
- Type 1 at x=384; `stop`=1 for x=384 and `stop`=0 for x=368:
  - Kick build: `cur_type`=2, `cur_x`=368, `rot_done` at N+4.
  - Non-kick build: `rot_fail` at N+2, type stays 1.
- `stop` held at 1 throughout:
  - Kick build: candidates x, x−16, x+16 in order, then `rot_fail` at N+6.
  - `cur_*` unchanged.
- `rot_req` edge while `freeze`=1, or a held `rot_req`, → no new rotation. `load` asserted during EVAL → `cur_*`=load values, IDLE next cycle, no pulses.
- `x_wr` to 336 while `busy` → ignored. `x_wr` in IDLE → `cur_x`=336 next cycle. Type 12 request → `rot_fail` at N+1.

Source files
------------

// File: rtl/rotate_ctrl_if.sv
// rotate_ctrl_if: candidate bus between the rotation sequencer and the collision checker
interface rotate_ctrl_if;
  logic [3:0] cand_type;
  logic [9:0] cand_x;
  logic       cand_valid;
  logic       stop;
  modport master (output cand_type, cand_x, cand_valid, input stop);
  modport slave (input cand_type, cand_x, cand_valid, output stop);
endinterface

// File: rtl/rotate_ctrl.sv
// rotate_ctrl: rotation sequencer for the active piece; define ROT_KICK_EN to enable wall-kick retries
module rotate_ctrl #(
  parameter int SIZE  = 16,
  parameter int X_MIN = 240,
  parameter int X_MAX = 400
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [3:0]          load_type,
  input  logic [9:0]          load_x,
  input  logic                x_wr,
  input  logic [9:0]          x_in,
  input  logic                freeze,
  input  logic                rot_req,
  rotate_ctrl_if.master       chk,
  output logic [3:0]          cur_type,
  output logic [9:0]          cur_x,
  output logic                busy,
  output logic                rot_done,
  output logic                rot_fail
);
  localparam logic [9:0] X_RST = 10'(X_MIN + 4 * SIZE);
  localparam logic [9:0] SZ = 10'(SIZE);
  if (X_MAX <= X_MIN + 4 * SIZE) begin : g_bad_field
    $error("rotate_ctrl: spawn column lies outside the playfield");
  end
  typedef enum logic [2:0] {IDLE, PROPOSE, EVAL, DONE, FAIL} state_t;
  state_t     state_q, state_d;
  logic [3:0] cur_type_q, cur_type_d, cand_type_q, cand_type_d;
  logic [9:0] cur_x_q, cur_x_d, cand_x_q, cand_x_d;
  logic [1:0] attempt_q, attempt_d;
  logic       skip_q, skip_d, rot_req_q;
  logic       busy_q, busy_d, cand_valid_q, cand_valid_d;
  logic       rot_done_q, rot_done_d, rot_fail_q, rot_fail_d;
  logic       req;
  function automatic logic [3:0] rot_map(input logic [3:0] t);
    case (t)
      4'd1:    rot_map = 4'd2;
      4'd2:    rot_map = 4'd1;
      4'd3:    rot_map = 4'd4;
      4'd4:    rot_map = 4'd5;
      4'd5:    rot_map = 4'd6;
      4'd6:    rot_map = 4'd3;
      4'd7:    rot_map = 4'd8;
      4'd8:    rot_map = 4'd7;
      4'd9:    rot_map = 4'd10;
      4'd10:   rot_map = 4'd9;
      default: rot_map = t;
    endcase
  endfunction
  assign req = rot_req & ~rot_req_q;
  // Type 0 and invalid types sit one silent cycle in DONE/FAIL (skip) so their pulse lands a cycle after accept
  always_comb begin
    state_d     = state_q;
    cur_type_d  = cur_type_q;
    cur_x_d     = cur_x_q;
    cand_type_d = cand_type_q;
    cand_x_d    = cand_x_q;
    attempt_d   = attempt_q;
    skip_d      = 1'b0;
    if (load) begin
      state_d    = IDLE;
      cur_type_d = load_type;
      cur_x_d    = load_x;
      attempt_d  = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (x_wr) cur_x_d = x_in;
          if (req && !freeze) begin
            if (cur_type_q == 4'd0) begin
              state_d = DONE;
              skip_d  = 1'b1;
            end else if (cur_type_q > 4'd10) begin
              state_d = FAIL;
              skip_d  = 1'b1;
            end else begin
              state_d     = PROPOSE;
              cand_type_d = rot_map(cur_type_q);
              cand_x_d    = cur_x_q;
              attempt_d   = 2'd0;
            end
          end
        end
        PROPOSE: state_d = EVAL;
        EVAL: begin
          if (!chk.stop) begin
            state_d    = DONE;
            cur_type_d = cand_type_q;
            cur_x_d    = cand_x_q;
          end else begin
`ifdef ROT_KICK_EN
            if (attempt_q == 2'd2) state_d = FAIL;
            else begin
              state_d   = PROPOSE;
              cand_x_d  = attempt_q == 2'd0 ? cur_x_q - SZ : cur_x_q + SZ;
              attempt_d = attempt_q + 2'd1;
            end
`else
            state_d = FAIL;
`endif
          end
        end
        default: state_d = skip_q ? state_q : IDLE;
      endcase
    end
    if (state_d inside {IDLE, DONE, FAIL}) begin
      cand_type_d = cur_type_d;
      cand_x_d    = cur_x_d;
    end
    busy_d       = state_d != IDLE;
    cand_valid_d = state_d == PROPOSE || state_d == EVAL;
    rot_done_d   = state_d == DONE && !skip_d;
    rot_fail_d   = state_d == FAIL && !skip_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_type_q   <= 4'd0;
      cur_x_q      <= X_RST;
      cand_type_q  <= 4'd0;
      cand_x_q     <= X_RST;
      attempt_q    <= 2'd0;
      skip_q       <= 1'b0;
      rot_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      rot_done_q   <= 1'b0;
      rot_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_type_q   <= cur_type_d;
      cur_x_q      <= cur_x_d;
      cand_type_q  <= cand_type_d;
      cand_x_q     <= cand_x_d;
      attempt_q    <= attempt_d;
      skip_q       <= skip_d;
      rot_req_q    <= rot_req;
      busy_q       <= busy_d;
      cand_valid_q <= cand_valid_d;
      rot_done_q   <= rot_done_d;
      rot_fail_q   <= rot_fail_d;
    end
  end
  assign chk.cand_type  = cand_type_q;
  assign chk.cand_x     = cand_x_q;
  assign chk.cand_valid = cand_valid_q;
  assign cur_type       = cur_type_q;
  assign cur_x          = cur_x_q;
  assign busy           = busy_q;
  assign rot_done       = rot_done_q;
  assign rot_fail       = rot_fail_q;
endmodule

// File: tb/tb_rotate_ctrl.sv
// tb_rotate_ctrl: table-driven cycle vectors plus hand sequences for kicks, all-blocked and load abort
module tb_rotate_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       load = 1'b0, x_wr = 1'b0, freeze = 1'b0, rot_req = 1'b0;
  logic [3:0] load_type = 4'd0;
  logic [9:0] load_x = 10'd0, x_in = 10'd0;
  logic [3:0] cur_type;
  logic [9:0] cur_x;
  logic       busy, rot_done, rot_fail;
  logic [1:0] sm = 2'd0;
  int         ncmp = 0, nbad = 0;
  rotate_ctrl_if chk ();
  rotate_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_type(load_type), .load_x(load_x),
    .x_wr(x_wr), .x_in(x_in), .freeze(freeze), .rot_req(rot_req), .chk(chk),
    .cur_type(cur_type), .cur_x(cur_x), .busy(busy), .rot_done(rot_done), .rot_fail(rot_fail)
  );
  always #5 clk = ~clk;
  always_comb chk.stop = sm == 2'd2 ? 1'b1 : sm == 2'd1 ? chk.cand_x == 10'd384 : 1'b0;
  typedef struct packed {
    logic       ld;
    logic [3:0] lt;
    logic [9:0] lx;
    logic       xw;
    logic [9:0] xi;
    logic       fz, rq;
    logic [3:0] et;
    logic [9:0] ex;
    logic [3:0] ct;
    logic [9:0] cx;
    logic       eb, ed, ef, ev;
  } vec_t;
  vec_t vec [35];
  function automatic vec_t v(logic ld, int lt, int lx, logic xw, int xi, logic fz, logic rq,
                             int et, int ex, int ct, int cx, logic eb, logic ed, logic ef, logic ev);
    return '{ld, 4'(lt), 10'(lx), xw, 10'(xi), fz, rq, 4'(et), 10'(ex), 4'(ct), 10'(cx), eb, ed, ef, ev};
  endfunction
  task automatic chk_eq(string n, logic [15:0] a, logic [15:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_in();
    load = 1'b0; x_wr = 1'b0; freeze = 1'b0; rot_req = 1'b0;
  endtask
  initial begin
    vec[0]  = v(1, 3, 320, 0, 0, 0, 0, 3, 320, 3, 320, 0, 0, 0, 0);
    vec[1]  = v(0, 0, 0, 0, 0, 0, 1, 3, 320, 4, 320, 1, 0, 0, 1);
    vec[2]  = v(0, 0, 0, 0, 0, 0, 1, 3, 320, 4, 320, 1, 0, 0, 1);
    vec[3]  = v(0, 0, 0, 0, 0, 0, 0, 4, 320, 4, 320, 1, 1, 0, 0);
    vec[4]  = v(0, 0, 0, 0, 0, 0, 0, 4, 320, 4, 320, 0, 0, 0, 0);
    vec[5]  = v(0, 0, 0, 0, 0, 0, 1, 4, 320, 5, 320, 1, 0, 0, 1);
    vec[6]  = v(0, 0, 0, 0, 0, 0, 0, 4, 320, 5, 320, 1, 0, 0, 1);
    vec[7]  = v(0, 0, 0, 0, 0, 0, 0, 5, 320, 5, 320, 1, 1, 0, 0);
    vec[8]  = v(0, 0, 0, 0, 0, 0, 0, 5, 320, 5, 320, 0, 0, 0, 0);
    vec[9]  = v(0, 0, 0, 0, 0, 0, 1, 5, 320, 6, 320, 1, 0, 0, 1);
    vec[10] = v(0, 0, 0, 0, 0, 0, 0, 5, 320, 6, 320, 1, 0, 0, 1);
    vec[11] = v(0, 0, 0, 0, 0, 0, 0, 6, 320, 6, 320, 1, 1, 0, 0);
    vec[12] = v(0, 0, 0, 0, 0, 0, 0, 6, 320, 6, 320, 0, 0, 0, 0);
    vec[13] = v(0, 0, 0, 0, 0, 0, 1, 6, 320, 3, 320, 1, 0, 0, 1);
    vec[14] = v(0, 0, 0, 0, 0, 0, 1, 6, 320, 3, 320, 1, 0, 0, 1);
    vec[15] = v(0, 0, 0, 0, 0, 0, 1, 3, 320, 3, 320, 1, 1, 0, 0);
    vec[16] = v(0, 0, 0, 0, 0, 0, 1, 3, 320, 3, 320, 0, 0, 0, 0);
    vec[17] = v(0, 0, 0, 0, 0, 0, 0, 3, 320, 3, 320, 0, 0, 0, 0);
    vec[18] = v(0, 0, 0, 0, 0, 1, 1, 3, 320, 3, 320, 0, 0, 0, 0);
    vec[19] = v(0, 0, 0, 0, 0, 0, 1, 3, 320, 3, 320, 0, 0, 0, 0);
    vec[20] = v(0, 0, 0, 0, 0, 0, 0, 3, 320, 3, 320, 0, 0, 0, 0);
    vec[21] = v(0, 0, 0, 1, 336, 0, 0, 3, 336, 3, 336, 0, 0, 0, 0);
    vec[22] = v(0, 0, 0, 0, 0, 0, 1, 3, 336, 4, 336, 1, 0, 0, 1);
    vec[23] = v(0, 0, 0, 1, 352, 0, 0, 3, 336, 4, 336, 1, 0, 0, 1);
    vec[24] = v(0, 0, 0, 0, 0, 0, 0, 4, 336, 4, 336, 1, 1, 0, 0);
    vec[25] = v(0, 0, 0, 0, 0, 0, 0, 4, 336, 4, 336, 0, 0, 0, 0);
    vec[26] = v(1, 12, 304, 0, 0, 0, 0, 12, 304, 12, 304, 0, 0, 0, 0);
    vec[27] = v(0, 0, 0, 0, 0, 0, 1, 12, 304, 12, 304, 1, 0, 0, 0);
    vec[28] = v(0, 0, 0, 0, 0, 0, 0, 12, 304, 12, 304, 1, 0, 1, 0);
    vec[29] = v(0, 0, 0, 0, 0, 0, 0, 12, 304, 12, 304, 0, 0, 0, 0);
    vec[30] = v(1, 0, 256, 0, 0, 0, 0, 0, 256, 0, 256, 0, 0, 0, 0);
    vec[31] = v(0, 0, 0, 0, 0, 0, 1, 0, 256, 0, 256, 1, 0, 0, 0);
    vec[32] = v(0, 0, 0, 0, 0, 0, 0, 0, 256, 0, 256, 1, 1, 0, 0);
    vec[33] = v(0, 0, 0, 0, 0, 0, 0, 0, 256, 0, 256, 0, 0, 0, 0);
    vec[34] = v(1, 1, 384, 1, 100, 0, 0, 1, 384, 1, 384, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_eq("rst_type", 16'(cur_type), 16'd0);
    chk_eq("rst_x", 16'(cur_x), 16'd304);
    chk_eq("rst_ctype", 16'(chk.cand_type), 16'd0);
    chk_eq("rst_cx", 16'(chk.cand_x), 16'd304);
    chk_eq("rst_flags", {12'd0, busy, rot_done, rot_fail, chk.cand_valid}, 16'd0);
    rst_n = 1'b1;
    step();
    chk_eq("idle_flags", {12'd0, busy, rot_done, rot_fail, chk.cand_valid}, 16'd0);
    for (int i = 0; i < 35; i++) begin
      load = vec[i].ld; load_type = vec[i].lt; load_x = vec[i].lx;
      x_wr = vec[i].xw; x_in = vec[i].xi; freeze = vec[i].fz; rot_req = vec[i].rq;
      step();
      chk_eq($sformatf("r%0d_type", i), 16'(cur_type), 16'(vec[i].et));
      chk_eq($sformatf("r%0d_x", i), 16'(cur_x), 16'(vec[i].ex));
      chk_eq($sformatf("r%0d_ctype", i), 16'(chk.cand_type), 16'(vec[i].ct));
      chk_eq($sformatf("r%0d_cx", i), 16'(chk.cand_x), 16'(vec[i].cx));
      chk_eq($sformatf("r%0d_busy", i), 16'(busy), 16'(vec[i].eb));
      chk_eq($sformatf("r%0d_done", i), 16'(rot_done), 16'(vec[i].ed));
      chk_eq($sformatf("r%0d_fail", i), 16'(rot_fail), 16'(vec[i].ef));
      chk_eq($sformatf("r%0d_cvalid", i), 16'(chk.cand_valid), 16'(vec[i].ev));
    end
    idle_in();
    sm = 2'd1; load = 1'b1; load_type = 4'd1; load_x = 10'd384;
    step();
    load = 1'b0; rot_req = 1'b1;
    step();
    rot_req = 1'b0;
    chk_eq("a_p0_cx", 16'(chk.cand_x), 16'd384);
    step();
`ifdef ROT_KICK_EN
    step();
    chk_eq("a_p1_cx", 16'(chk.cand_x), 16'd368);
    chk_eq("a_p1_done", 16'(rot_done), 16'd0);
    step();
    step();
    chk_eq("a_done", 16'(rot_done), 16'd1);
    chk_eq("a_type", 16'(cur_type), 16'd2);
    chk_eq("a_x", 16'(cur_x), 16'd368);
`else
    step();
    chk_eq("a_fail", 16'(rot_fail), 16'd1);
    chk_eq("a_type", 16'(cur_type), 16'd1);
    chk_eq("a_x", 16'(cur_x), 16'd384);
`endif
    step();
    chk_eq("a_idle", {13'd0, busy, rot_done, rot_fail}, 16'd0);
    sm = 2'd2; load = 1'b1; load_type = 4'd7; load_x = 10'd320;
    step();
    load = 1'b0; rot_req = 1'b1;
    step();
    rot_req = 1'b0;
    chk_eq("b_p0_cx", 16'(chk.cand_x), 16'd320);
    chk_eq("b_p0_ctype", 16'(chk.cand_type), 16'd8);
    step();
`ifdef ROT_KICK_EN
    step();
    chk_eq("b_p1_cx", 16'(chk.cand_x), 16'd304);
    step();
    step();
    chk_eq("b_p2_cx", 16'(chk.cand_x), 16'd336);
    chk_eq("b_p2_fail", 16'(rot_fail), 16'd0);
    step();
    step();
`else
    step();
`endif
    chk_eq("b_fail", 16'(rot_fail), 16'd1);
    chk_eq("b_type", 16'(cur_type), 16'd7);
    chk_eq("b_x", 16'(cur_x), 16'd320);
    chk_eq("b_cx", 16'(chk.cand_x), 16'd320);
    step();
    chk_eq("b_idle", {13'd0, busy, rot_done, rot_fail}, 16'd0);
    sm = 2'd0; load = 1'b1; load_type = 4'd5; load_x = 10'd256;
    step();
    load = 1'b0; rot_req = 1'b1;
    step();
    rot_req = 1'b0;
    step();
    chk_eq("c_eval_cv", 16'(chk.cand_valid), 16'd1);
    load = 1'b1; load_type = 4'd9; load_x = 10'd272;
    step();
    load = 1'b0;
    chk_eq("c_type", 16'(cur_type), 16'd9);
    chk_eq("c_x", 16'(cur_x), 16'd272);
    chk_eq("c_flags", {12'd0, busy, rot_done, rot_fail, chk.cand_valid}, 16'd0);
    step();
    chk_eq("c_flags2", {12'd0, busy, rot_done, rot_fail, chk.cand_valid}, 16'd0);
    chk_eq("c_type2", 16'(cur_type), 16'd9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
